// File: rtl/clock_pkg.sv
// Shared time-keeping types and default moduli for the clock/alarm datapath.
package clock_pkg;

  localparam int unsigned NS = 60;
  localparam int unsigned NH = 24;
  localparam int unsigned ND = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } alarm_state_t;

  typedef logic [6:0] time_field_t;

endpackage

// File: rtl/sec_downcounter.sv
// Loadable seconds down-counter; holds at zero instead of wrapping.
module sec_downcounter #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;
  logic [W-1:0] w_count_nxt;

  always_comb begin
    w_count_nxt = r_count;
    if (i_load) begin
      w_count_nxt = i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      w_count_nxt = r_count - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/alarm_snooze_ctrl.sv
// Alarm sequencer: ring timeout, capped snooze, and suppression while editing.
// Optional build macro BUZZ_PATTERN_EN pulses buzz 1 s on / 1 s off while ringing.
module alarm_snooze_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned NS       = clock_pkg::NS,
  parameter int unsigned NH       = clock_pkg::NH,
  parameter int unsigned ND       = clock_pkg::ND,
  parameter int unsigned RING_S   = 60,
  parameter int unsigned SNOOZE_S = 300,
  parameter int unsigned MAX_SNZ  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  time_field_t tsec,
  input  time_field_t tmin,
  input  time_field_t thrs,
  input  time_field_t tdays,
  input  time_field_t amin,
  input  time_field_t ahrs,
  input  time_field_t adays,
  input  logic        alarm_on,
  input  logic        alarm_set,
  input  logic        snooze,
  output logic        buzz,
  output logic        snoozing
);

  localparam int unsigned CW = $clog2((RING_S > SNOOZE_S) ? RING_S : SNOOZE_S) + 1;
  localparam int unsigned UW = (MAX_SNZ < 2) ? 1 : $clog2(MAX_SNZ + 1);

`ifdef BUZZ_PATTERN_EN
  localparam logic RING_LSB0 = 1'((RING_S - 1) % 2);
`endif

  alarm_state_t   r_state;
  alarm_state_t   w_state_nxt;
  logic [UW-1:0]  r_snz_used;
  logic           r_buzz;
  logic           r_snoozing;

  logic           w_time_ok;
  logic           w_hit;
  logic           w_snz_avail;
  logic           w_ring_load;
  logic           w_ring_dec;
  logic           w_snz_load;
  logic           w_snz_dec;
  logic           w_ring_zero;
  logic           w_snz_zero;
  logic           w_buzz_nxt;
  logic           w_snoozing_nxt;
  logic [CW-1:0]  w_ring_ct;
  logic [CW-1:0]  w_snz_ct;

  // Out-of-range time fields (counter glitch, mid-edit) never match.
  assign w_time_ok = (32'(tmin) < NS) && (32'(thrs) < NH);

  assign w_hit = (tsec == '0) && (tmin == amin) && (thrs == ahrs) &&
                 ((32'(adays) == ND) || (adays == tdays)) &&
                 alarm_on && !alarm_set && w_time_ok;

  assign w_snz_avail = (32'(r_snz_used) < MAX_SNZ);
  assign w_ring_zero = (w_ring_ct == '0);
  assign w_snz_zero  = (w_snz_ct == '0);

  sec_downcounter #(.W(CW)) u_ring_ct (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_ring_load),
    .i_load_val (CW'(RING_S - 1)),
    .i_dec      (w_ring_dec),
    .o_count    (w_ring_ct)
  );

  sec_downcounter #(.W(CW)) u_snz_ct (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_snz_load),
    .i_load_val (CW'(SNOOZE_S - 1)),
    .i_dec      (w_snz_dec),
    .o_count    (w_snz_ct)
  );

  // Next-state, counter control, and next-cycle output decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_ring_load    = 1'b0;
    w_ring_dec     = 1'b0;
    w_snz_load     = 1'b0;
    w_snz_dec      = 1'b0;
    w_buzz_nxt     = 1'b0;
    w_snoozing_nxt = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_hit) begin
          w_state_nxt = RINGING;
          w_ring_load = 1'b1;
        end
      end
      RINGING: begin
        if (!alarm_on) begin
          w_state_nxt = IDLE;
        end else if (snooze && w_snz_avail) begin
          w_state_nxt = SNOOZE;
          w_snz_load  = 1'b1;
        end else if (w_ring_zero) begin
          w_state_nxt = IDLE;
        end else begin
          w_ring_dec = 1'b1;
        end
      end
      SNOOZE: begin
        if (!alarm_on) begin
          w_state_nxt = IDLE;
        end else if (w_snz_zero) begin
          w_state_nxt = RINGING;
          w_ring_load = 1'b1;
        end else begin
          w_snz_dec = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_snoozing_nxt = (w_state_nxt == SNOOZE);
`ifdef BUZZ_PATTERN_EN
    // buzz tracks ring_ct[0]: staying in RINGING always decrements, so parity flips.
    if (w_state_nxt == RINGING) begin
      w_buzz_nxt = w_ring_load ? RING_LSB0 : ~r_buzz;
    end
`else
    w_buzz_nxt = (w_state_nxt == RINGING);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_snz_used <= '0;
      r_buzz     <= 1'b0;
      r_snoozing <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_buzz     <= w_buzz_nxt;
      r_snoozing <= w_snoozing_nxt;
      if ((r_state == IDLE) && (w_state_nxt == RINGING)) begin
        r_snz_used <= '0;
      end else if (w_snz_load && w_snz_avail) begin
        r_snz_used <= r_snz_used + UW'(1);
      end
    end
  end

  assign buzz     = r_buzz;
  assign snoozing = r_snoozing;

endmodule

// File: doc/alarm_snooze_ctrl.md
Name: alarm_snooze_ctrl

Overview:
- Alarm sequencer that sits directly downstream of the clock/alarm counters.
- Consumes the running time (sec/min/hrs/day) and the alarm setting (min/hrs/day); drives the buzzer output.
- Adds ring timeout, a snooze countdown with a capped snooze count, and suppression while the alarm is being set.
- Clocked by the 1 Hz Pulse, so 1 clk = 1 s.

Parameters:
- NS, 60, seconds/minutes modulus.
- NH, 24, hours modulus.
- ND, 7, days modulus. adays == ND is the "every day" wildcard.
- RING_S, 60, seconds of ringing before auto-stop.
- SNOOZE_S, 300, seconds of snooze before re-ring.
- MAX_SNZ, 3, snoozes honoured per alarm event.

Ports:
- clk  in  1  1 Hz Pulse.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- tsec  in  7  current seconds, 0..NS-1.
- tmin  in  7  current minutes.
- thrs  in  7  current hours.
- tdays  in  7  current day, 0..ND-1.
- amin  in  7  alarm minutes.
- ahrs  in  7  alarm hours.
- adays  in  7  alarm day, 0..ND; ND = any day.
- alarm_on  in  1  master alarm enable (level).
- alarm_set  in  1  alarm being edited; suppresses triggering.
- snooze  in  1  snooze button (level, sampled each clk).
- buzz  out  1  registered buzzer drive.
- snoozing  out  1  registered; high in SNOOZE.

Behaviour:
- Reset (rst = 0, async): state IDLE; buzz = 0; snoozing = 0; ring_ct = 0; snz_ct = 0; snz_used = 0.
- hit (combinational) = tsec==0 && tmin==amin && thrs==ahrs && (adays==ND || adays==tdays) && alarm_on && !alarm_set.
- IDLE:
  - hit → RINGING on the next edge; ring_ct = RING_S-1; snz_used = 0.
  - Latency: buzz is high starting in the cycle where tsec==1.
- RINGING (buzz = 1):
  - Priority order: !alarm_on → IDLE; snooze && snz_used < MAX_SNZ → SNOOZE; ring_ct == 0 → IDLE; else ring_ct decrements.
  - snooze with snz_used == MAX_SNZ is ignored.
- SNOOZE (buzz = 0, snoozing = 1):
  - On entry: snz_ct = SNOOZE_S-1; snz_used increments (saturating at MAX_SNZ).
  - !alarm_on → IDLE.
  - snz_ct == 0 → RINGING with ring_ct reloaded to RING_S-1.
  - Otherwise snz_ct decrements; snooze is ignored.
- hit while in RINGING or SNOOZE: ignored; the current event continues.
- alarm_set high mid-event: no effect on an event already in progress. It blocks new triggers only.
- alarm_on low: return to IDLE at the next edge, so buzz = 0 one cycle later.
- Output timing: buzz and snoozing are pure registered decodes of next state. No combinational path from inputs to outputs.
- Counter widths: $clog2 of the larger of RING_S and SNOOZE_S, plus 1.
  - Counters never wrap; they reload only on state entry.
- Reset mid-event: immediate IDLE with buzz = 0 (async).

Optional Feature:
- Macro BUZZ_PATTERN_EN.
- Defined: in RINGING, buzz = ring_ct[0], giving a 1 s on / 1 s off pattern. First ringing cycle has ring_ct = RING_S-1 = 59, so buzz = 1.
- Undefined: buzz is steady 1 throughout RINGING.
- State transitions are identical in both builds.

Decomposition:
- Package clock_pkg holds:
  - NS, NH, ND default localparams.
  - typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} alarm_state_t.
  - typedef logic [6:0] time_field_t.
- One sub-module, sec_downcounter (load, dec, zero flag), instantiated twice: ring and snooze.

Test Plan:
- Basic trigger:
  - Stimulus: amin=30, ahrs=7, adays=2, alarm_on=1; time sweeps to 2/07:30:00.
  - Required: buzz=0 at tsec=0, buzz=1 from tsec=1 for exactly 60 cycles, then 0.
- Day wildcard:
  - Stimulus: adays=7, same time on tdays=5.
  - Required: triggers. With adays=3 and tdays=5: no trigger.
- Snooze cycle:
  - Stimulus: snooze pulsed 10 s into ringing.
  - Required: buzz=0 and snoozing=1 for 300 cycles, then buzz=1 again with a fresh 60 s ring.
- Snooze cap:
  - Stimulus: snooze pressed on every ring.
  - Required: 3 snoozes honoured; the 4th press is ignored and buzz runs the full 60 s, then IDLE.
- Kill:
  - Stimulus: alarm_on dropped mid-ring and, separately, mid-snooze.
  - Required: buzz=0 and snoozing=0 after one edge. With alarm_set=1 at the match time: no trigger.
- Reset:
  - Stimulus: rst=0 asserted between edges during RINGING.
  - Required: buzz=0 immediately; after release, no ring until the next match.
  - BUZZ_PATTERN_EN build: buzz alternates 1,0,1,… across the 60-cycle ring.
